mdu_sched: RTL and testbench

Issue scheduler between the E-stage and the MDU. It buffers mult/div/madd/msub and mthi/mtlo requests in a small in-order queue, so back-to-back MDU instructions do not stall the pipeline. It launches queued requests into the MDU one at a time, honouring the MDU's busy timing. It raises a stall for HI/LO reads (mfhi/mflo) until every older request has retired into HI/LO, and it aborts everything on an exception flush.

---
 rtl/mdu_sched_pkg.sv | 37 +++
 rtl/mdu_req_fifo.sv | 47 ++++
 rtl/mdu_sched.sv | 86 ++++++++
 tb/tb_mdu_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sched_pkg.sv
// Shared MDU op codes, MTHI/MTLO codes, scheduler FSM states and the queued request layout.
package mdu_sched_pkg;

   localparam int unsigned OP_W   = 4;
   localparam int unsigned MT_W   = 2;
   localparam int unsigned DATA_W = 32;

   localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
   localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
   localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
   localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
   localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
   localparam logic [OP_W-1:0] MDU_MADD  = 4'd5;
   localparam logic [OP_W-1:0] MDU_MADDU = 4'd6;
   localparam logic [OP_W-1:0] MDU_MSUB  = 4'd7;
   localparam logic [OP_W-1:0] MDU_MSUBU = 4'd8;

   localparam logic [MT_W-1:0] MT_NONE = 2'b00;
   localparam logic [MT_W-1:0] MT_LO   = 2'b01;
   localparam logic [MT_W-1:0] MT_HI   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [MT_W-1:0]   mt;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } mdu_req_t;

   localparam int unsigned REQ_W = $bits(mdu_req_t);

endpackage

// File: rtl/mdu_req_fifo.sv
// In-order request queue: DEPTH entries of one packed MDU request, flush empties it.
module mdu_req_fifo
   import mdu_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [REQ_W-1:0] din,
   output logic [REQ_W-1:0] head,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned CNT_W = PTR_W + 1;

   logic [REQ_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mdu_sched.sv
// Issue scheduler between E-stage and MDU: queues requests, launches them one at a time,
// stalls HI/LO reads behind older writes, and aborts on flush.
module mdu_sched
   import mdu_sched_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [1:0]  req_mt,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   input  logic        hilo_rd,
   output logic        hilo_stall,
   input  logic        flush,
   output logic [3:0]  mdu_op,
   output logic [1:0]  mdu_mthilo,
   output logic [31:0] mdu_a,
   output logic [31:0] mdu_b,
   output logic        mdu_clr,
   output logic        mdu_exc,
   input  logic        mdu_busy,
   output logic        idle
);

   state_t         state;
   mdu_req_t       head;
   logic [PTR_W:0] count;
   logic           full;
   logic           empty;
   logic           launch;
   logic           push;
   logic           no_entry;

   // Head launches only from IDLE; an entry pushed this cycle is not yet visible at the head.
   assign launch    = (state == S_IDLE) & ~empty & ~flush & ~reset;
   assign req_ready = ~flush & (~full | launch);
   assign no_entry  = (req_op == MDU_NONE) & (req_mt == MT_NONE);
   assign push      = req_valid & req_ready & ~no_entry & ~hilo_stall;

   mdu_req_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (launch),
      .flush (flush),
      .din   ({req_op, req_mt, req_a, req_b}),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // mthi/mtlo entries complete on the launch edge, so they never leave IDLE.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:   if (launch && head.op != MDU_NONE) state <= S_LAUNCH;
            S_LAUNCH: state <= S_RUN;
            S_RUN:    if (!mdu_busy) state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign mdu_op     = launch ? head.op : MDU_NONE;
   assign mdu_mthilo = launch ? head.mt : MT_NONE;
   assign mdu_a      = launch ? head.a  : '0;
   assign mdu_b      = launch ? head.b  : '0;
   assign mdu_clr    = flush & ~reset;
   assign mdu_exc    = flush & ~reset;

   // A HI/LO read waits until nothing older is queued, launching or executing.
   assign hilo_stall = hilo_rd & (~empty | (state != S_IDLE) | mdu_busy | launch);
   assign idle       = (count == '0) & (state == S_IDLE) & ~mdu_busy;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched with a behavioural MDU (5-cycle mult, 10-cycle div) holding HI/LO.
module tb_mdu_sched;
   import mdu_sched_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [1:0]  req_mt;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        req_ready;
   logic        hilo_rd;
   logic        hilo_stall;
   logic        flush;
   logic [3:0]  mdu_op;
   logic [1:0]  mdu_mthilo;
   logic [31:0] mdu_a;
   logic [31:0] mdu_b;
   logic        mdu_clr;
   logic        mdu_exc;
   logic        mdu_busy;
   logic        idle;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   mdu_sched #(.DEPTH(2), .PTR_W(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_mt     (req_mt),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .hilo_rd    (hilo_rd),
      .hilo_stall (hilo_stall),
      .flush      (flush),
      .mdu_op     (mdu_op),
      .mdu_mthilo (mdu_mthilo),
      .mdu_a      (mdu_a),
      .mdu_b      (mdu_b),
      .mdu_clr    (mdu_clr),
      .mdu_exc    (mdu_exc),
      .mdu_busy   (mdu_busy),
      .idle       (idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural MDU: start is registered, busy rises one cycle after the launch cycle.
   logic [31:0] hi, lo, st_a, st_b, res_hi, res_lo;
   logic [3:0]  st_op, cnt;

   function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
      logic signed [63:0] sp;
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      case (op)
         MDU_MULT:  return sp;
         MDU_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_DIV:   return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
         MDU_DIVU:  return {a % b, a / b};
         MDU_MADD:  return acc + sp;
         MDU_MSUB:  return acc - sp;
         default:   return acc;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         hi <= '0; lo <= '0; st_op <= '0; st_a <= '0; st_b <= '0;
         cnt <= '0; mdu_busy <= 1'b0; res_hi <= '0; res_lo <= '0;
      end else if (mdu_clr) begin
         st_op <= '0; cnt <= '0; mdu_busy <= 1'b0;
      end else begin
         st_op <= mdu_op; st_a <= mdu_a; st_b <= mdu_b;
         if (mdu_mthilo == MT_LO) lo <= mdu_a;
         else if (mdu_mthilo == MT_HI) hi <= mdu_a;
         if (st_op != MDU_NONE) begin
            mdu_busy <= 1'b1;
            cnt <= (st_op == MDU_DIV || st_op == MDU_DIVU) ? 4'd10 : 4'd5;
            {res_hi, res_lo} <= calc(st_op, st_a, st_b, {hi, lo});
         end else if (mdu_busy) begin
            if (cnt == 4'd1) begin
               mdu_busy <= 1'b0; hi <= res_hi; lo <= res_lo;
            end
            cnt <= cnt - 4'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      req_valid = 1'b0; req_op = MDU_NONE; req_mt = MT_NONE;
      req_a = '0; req_b = '0; hilo_rd = 1'b0; flush = 1'b0;
   endtask

   task automatic req(input logic [3:0] op, input logic [1:0] mt,
                      input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1; req_op = op; req_mt = mt; req_a = a; req_b = b;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Advance until idle; returns cycles waited or -1 on timeout.
   task automatic wait_idle(input int limit, output int waited);
      waited = -1;
      for (int i = 1; i <= limit; i++) begin
         next(); #1;
         if (idle) begin waited = i; break; end
      end
      if (waited < 0) check("idle_timeout", 32'd0, 32'd1);
   endtask

   int t0, w, rel, mt_cyc, stalls;
   logic [31:0] sv_hi, sv_lo;

   initial begin
      clr_in();
      reset = 1'b1;
      next(); next();
      reset = 1'b0;
      #1;
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_stall", 32'(hilo_stall), 32'd0);
      check("rst_op", 32'(mdu_op), 32'd0);
      check("rst_mt", 32'(mdu_mthilo), 32'd0);
      check("rst_ab", mdu_a | mdu_b, 32'd0);
      check("rst_clr", 32'({mdu_clr, mdu_exc}), 32'd0);
      check("rst_idle", 32'(idle), 32'd1);

      // 1: mult 3 x -2; mflo in E the cycle after launch stalls 7 cycles
      next(); req(MDU_MULT, MT_NONE, 32'd3, 32'hFFFF_FFFE); #1;
      check("t1_ready", 32'(req_ready), 32'd1);
      check("t1_nobypass", 32'(mdu_op), 32'(MDU_NONE));
      next(); clr_in(); #1;
      check("t1_launch_op", 32'(mdu_op), 32'(MDU_MULT));
      check("t1_launch_a", mdu_a, 32'd3);
      next(); hilo_rd = 1'b1; #1;
      stalls = 0; rel = 0;
      for (int i = 0; i < 40; i++) begin
         if (!hilo_stall) begin rel = 1; break; end
         stalls++;
         next(); #1;
      end
      check("t1_released", 32'(rel), 32'd1);
      check("t1_stall_cycles", 32'(stalls), 32'd7);
      check("t1_hi", hi, 32'hFFFF_FFFF);
      check("t1_lo", lo, 32'hFFFF_FFFA);
      next(); clr_in();

      // 2: multu 5x6 then divu 100/7 back to back
      next(); req(MDU_MULTU, MT_NONE, 32'd5, 32'd6); #1;
      check("t2_ready0", 32'(req_ready), 32'd1);
      next(); req(MDU_DIVU, MT_NONE, 32'd100, 32'd7); #1;
      check("t2_ready1", 32'(req_ready), 32'd1);
      check("t2_multu_launch", 32'(mdu_op), 32'(MDU_MULTU));
      t0 = cyc; rel = 0;
      next(); clr_in(); #1;
      for (int i = 0; i < 40; i++) begin
         if (mdu_op == MDU_DIVU) begin rel = 1; break; end
         next(); #1;
      end
      check("t2_divu_seen", 32'(rel), 32'd1);
      check("t2_divu_latency", 32'(cyc - t0), 32'd8);
      check("t2_divu_busy_low", 32'(mdu_busy), 32'd0);
      wait_idle(40, w);
      check("t2_idle_after", 32'(w), 32'd13);
      check("t2_hi", hi, 32'd2);
      check("t2_lo", lo, 32'd14);

      // 3: queue fills; fourth request waits for the next launch
      next(); req(MDU_MULT, MT_NONE, 32'd2, 32'd3); #1;
      check("t3_ready_a", 32'(req_ready), 32'd1);
      next(); req(MDU_MULT, MT_NONE, 32'd4, 32'd5); #1;
      check("t3_ready_b", 32'(req_ready), 32'd1);
      next(); req(MDU_MULT, MT_NONE, 32'd6, 32'd7); #1;
      check("t3_ready_c", 32'(req_ready), 32'd1);
      next(); req(MDU_MULT, MT_NONE, 32'd7, 32'd8); #1;
      check("t3_full_ready", 32'(req_ready), 32'd0);
      rel = 0;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin rel = 1; break; end
         next(); #1;
      end
      check("t3_ready_seen", 32'(rel), 32'd1);
      check("t3_ready_on_launch", 32'(mdu_op), 32'(MDU_MULT));
      check("t3_launch_a", mdu_a, 32'd4);
      next(); clr_in();
      wait_idle(60, w);
      check("t3_hi", hi, 32'd0);
      check("t3_lo", lo, 32'd56);

      // 4: mtlo behind div; mflo released the cycle after the mtlo launch
      next(); req(MDU_DIV, MT_NONE, 32'd100, 32'd7);
      next(); req(MDU_NONE, MT_LO, 32'h1234, 32'd0); #1;
      check("t4_mt_ready", 32'(req_ready), 32'd1);
      next(); clr_in(); hilo_rd = 1'b1; #1;
      mt_cyc = -10; rel = -1;
      for (int i = 0; i < 40; i++) begin
         if (mdu_mthilo == MT_LO) mt_cyc = cyc;
         if (!hilo_stall) begin rel = cyc; break; end
         next(); #1;
      end
      check("t4_release", 32'(rel - mt_cyc), 32'd1);
      check("t4_lo", lo, 32'h1234);
      check("t4_hi", hi, 32'd2);
      next(); clr_in();

      // 5: flush two cycles into a div with a mult queued
      sv_hi = hi; sv_lo = lo;
      next(); req(MDU_DIV, MT_NONE, 32'd1000, 32'd3);
      next(); req(MDU_MULT, MT_NONE, 32'd9, 32'd9); #1;
      check("t5_div_launch", 32'(mdu_op), 32'(MDU_DIV));
      next(); clr_in();
      next(); flush = 1'b1; req(MDU_MULT, MT_NONE, 32'd2, 32'd2); #1;
      check("t5_busy_before", 32'(mdu_busy), 32'd1);
      check("t5_clr_exc", 32'({mdu_clr, mdu_exc}), 32'd3);
      check("t5_ready", 32'(req_ready), 32'd0);
      check("t5_no_launch", 32'(mdu_op), 32'd0);
      next(); clr_in(); #1;
      check("t5_clr_pulse", 32'(mdu_clr), 32'd0);
      check("t5_idle", 32'(idle), 32'd1);
      for (int i = 0; i < 15; i++) next();
      #1;
      check("t5_still_idle", 32'(idle), 32'd1);
      check("t5_hi", hi, sv_hi);
      check("t5_lo", lo, sv_lo);

      // 6: reset with two entries queued and an op running
      next(); req(MDU_MULT, MT_NONE, 32'd1, 32'd1);
      next(); req(MDU_MULT, MT_NONE, 32'd2, 32'd2);
      next(); req(MDU_MULT, MT_NONE, 32'd3, 32'd3);
      next(); clr_in(); reset = 1'b1; #1;
      check("t6_full", 32'(req_ready), 32'd0);
      check("t6_busy_state", 32'(idle), 32'd0);
      next(); reset = 1'b0; #1;
      check("t6_ready", 32'(req_ready), 32'd1);
      check("t6_idle", 32'(idle), 32'd1);
      check("t6_op", 32'(mdu_op), 32'd0);
      check("t6_hilo", hi | lo, 32'd0);
      for (int i = 0; i < 15; i++) next();
      #1;
      check("t6_no_run", lo, 32'd0);
      check("t6_idle_late", 32'(idle), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
